// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, the forward S-box, the GF(2^8)
// doubling used for rcon, and the key-expansion FSM state encoding.
package aes_pkg;

   localparam int Nb         = 4;
   localparam int WORD_SIZE  = 32;
   localparam int BLOCK_SIZE = 128;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [WORD_SIZE-1:0] rot_word(input logic [WORD_SIZE-1:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/key_schedule_engine_if.sv
// Request/schedule bundle between the cipher control (master) and the
// key expansion engine (slave).
interface key_schedule_engine_if #(
   parameter int Nk = 4,
   parameter int Nr = 10
);
   import aes_pkg::*;

   logic                            start;
   logic [Nk*WORD_SIZE-1:0]         key;
   logic [BLOCK_SIZE*(Nr+1)-1:0]    round_keys;
   logic                            busy;
   logic                            key_valid;

   modport master (
      output start, key,
      input  round_keys, busy, key_valid
   );

   modport slave (
      input  start, key,
      output round_keys, busy, key_valid
   );

endinterface

// File: rtl/sub_word.sv
// Byte-wise S-box substitution of one 32-bit word; purely combinational so
// the cipher's SubBytes stage can reuse it.
module sub_word
   import aes_pkg::*;
(
   input  logic [WORD_SIZE-1:0] in_word,
   output logic [WORD_SIZE-1:0] out_word
);

   assign out_word = {SBOX[in_word[31:24]], SBOX[in_word[23:16]],
                      SBOX[in_word[15:8]],  SBOX[in_word[7:0]]};

endmodule

// File: rtl/key_schedule_engine.sv
// Iterative AES key expansion: one schedule word per clock, schedule held
// stable in DONE with key_valid high until the next accepted start.
module key_schedule_engine
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
)(
   input  logic                  clk,
   input  logic                  reset_n,
   key_schedule_engine_if.slave  ks
);

   localparam int              NW        = Nb * (Nr + 1);
   localparam logic [5:0]      NK_IDX    = 6'(Nk);
   localparam logic [5:0]      LAST_IDX  = 6'(NW - 1);
   localparam logic [2:0]      PHASE_MAX = 3'(Nk - 1);

   state_t                 state_q, state_d;
   logic [5:0]             i_q, i_d;
   logic [2:0]             phase_q, phase_d;
   logic [7:0]             rcon_q, rcon_d;
   logic                   busy_q, busy_d;
   logic                   key_valid_q, key_valid_d;
   logic [WORD_SIZE-1:0]   w_q [NW];
   logic [WORD_SIZE-1:0]   w_d [NW];

   logic [WORD_SIZE-1:0]   prev_word;
   logic [WORD_SIZE-1:0]   back_word;
   logic [WORD_SIZE-1:0]   sub_in;
   logic [WORD_SIZE-1:0]   sub_out;
   logic [WORD_SIZE-1:0]   temp;

   assign prev_word = w_q[i_q - 6'd1];
   assign back_word = w_q[i_q - NK_IDX];

   // Rotation only applies on the i mod Nk == 0 words; one S-box bank serves both cases.
   assign sub_in = (phase_q == 3'd0) ? rot_word(prev_word) : prev_word;

   sub_word u_sub_word (
      .in_word  (sub_in),
      .out_word (sub_out)
   );

   always_comb begin
      temp = prev_word;
      if (phase_q == 3'd0) begin
         temp = sub_out ^ {rcon_q, 24'h0};
      end else if (Nk == 8 && phase_q == 3'd4) begin
         temp = sub_out;
      end
   end

   // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      phase_d     = phase_q;
      rcon_d      = rcon_q;
      busy_d      = busy_q;
      key_valid_d = key_valid_q;
      w_d         = w_q;

      case (state_q)
         IDLE, DONE: begin
            if (ks.start) begin
               for (int k = 0; k < Nk; k++) begin
                  w_d[k] = ks.key[(Nk-1-k)*WORD_SIZE +: WORD_SIZE];
               end
               i_d         = NK_IDX;
               phase_d     = 3'd0;
               rcon_d      = 8'h01;
               state_d     = EXPAND;
               busy_d      = 1'b1;
               key_valid_d = 1'b0;
            end
         end
         EXPAND: begin
            w_d[i_q] = back_word ^ temp;
            i_d      = i_q + 6'd1;
            phase_d  = (phase_q == PHASE_MAX) ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd0) begin
               rcon_d = xtime(rcon_q);
            end
            if (i_q == LAST_IDX) begin
               state_d     = DONE;
               busy_d      = 1'b0;
               key_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            key_valid_d = 1'b0;
         end
      endcase
   end

   // NOTE: the schedule is a bank of flops feeding a flat output, not a RAM,
   // so it is reset along with the control state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         i_q         <= 6'd0;
         phase_q     <= 3'd0;
         rcon_q      <= 8'h01;
         busy_q      <= 1'b0;
         key_valid_q <= 1'b0;
         for (int k = 0; k < NW; k++) begin
            w_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         phase_q     <= phase_d;
         rcon_q      <= rcon_d;
         busy_q      <= busy_d;
         key_valid_q <= key_valid_d;
         w_q         <= w_d;
      end
   end

   for (genvar k = 0; k < NW; k++) begin : g_flat
      assign ks.round_keys[(NW-1-k)*WORD_SIZE +: WORD_SIZE] = w_q[k];
   end

   assign ks.busy      = busy_q;
   assign ks.key_valid = key_valid_q;

endmodule

// File: tb/tb_key_schedule_engine.sv
// Directed bench for key_schedule_engine against the FIPS-197 expansion
// vectors for AES-128/192/256, plus restart, ignored-start and reset cases.
module tb_key_schedule_engine;

   logic clk;
   logic reset_n;

   int total = 0;
   int bad   = 0;

   localparam logic [255:0] KEY_A1 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [255:0] KEY_C1 = 256'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] KEY_A2 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   key_schedule_engine_if #(.Nk(4), .Nr(10)) if4 ();
   key_schedule_engine_if #(.Nk(6), .Nr(12)) if6 ();
   key_schedule_engine_if #(.Nk(8), .Nr(14)) if8 ();

   key_schedule_engine #(.Nk(4), .Nr(10)) dut4 (.clk(clk), .reset_n(reset_n), .ks(if4.slave));
   key_schedule_engine #(.Nk(6), .Nr(12)) dut6 (.clk(clk), .reset_n(reset_n), .ks(if6.slave));
   key_schedule_engine #(.Nk(8), .Nr(14)) dut8 (.clk(clk), .reset_n(reset_n), .ks(if8.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic s, input logic [255:0] k);
      case (sel)
         4:       begin if4.start = s; if4.key = k[127:0]; end
         6:       begin if6.start = s; if6.key = k[191:0]; end
         default: begin if8.start = s; if8.key = k;        end
      endcase
   endtask

   function automatic logic kv(input int sel);
      case (sel)
         4:       return if4.key_valid;
         6:       return if6.key_valid;
         default: return if8.key_valid;
      endcase
   endfunction

   function automatic logic bsy(input int sel);
      case (sel)
         4:       return if4.busy;
         6:       return if6.busy;
         default: return if8.busy;
      endcase
   endfunction

   function automatic logic [31:0] word(input int sel, input int i);
      case (sel)
         4:       return if4.round_keys[1407 - 32*i -: 32];
         6:       return if6.round_keys[1663 - 32*i -: 32];
         default: return if8.round_keys[1919 - 32*i -: 32];
      endcase
   endfunction

   // Accept a start, then count edges until key_valid; optionally pulse a
   // second start with key k2 after inject_at edges of expansion.
   task automatic run(input string tag, input int sel, input logic [255:0] k,
                      input int inject_at, input logic [255:0] k2, output int lat);
      @(negedge clk);
      drive(sel, 1'b1, k);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, k);
      check({tag, "_busy_after_accept"}, 64'(bsy(sel)), 64'd1);
      check({tag, "_kv_after_accept"}, 64'(kv(sel)), 64'd0);
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (inject_at != 0 && lat == inject_at) drive(sel, 1'b1, k2);
         else                                    drive(sel, 1'b0, k);
         if (kv(sel)) break;
      end
      drive(sel, 1'b0, k);
      if (!kv(sel)) check({tag, "_kv_timeout"}, 64'(kv(sel)), 64'd1);
      check({tag, "_busy_at_done"}, 64'(bsy(sel)), 64'd0);
   endtask

   initial begin
      int lat;
      reset_n = 1'b0;
      drive(4, 1'b0, '0);
      drive(6, 1'b0, '0);
      drive(8, 1'b0, '0);
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(if4.busy), 64'd0);
      check("rst_kv", 64'(if4.key_valid), 64'd0);
      check("rst_rk_zero", 64'(|if4.round_keys), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 64'(if4.busy), 64'd0);

      // AES-128 FIPS-197 A.1
      run("a1", 4, KEY_A1, 0, '0, lat);
      check("a1_latency", 64'(lat), 64'd40);
      check("a1_w0", 64'(word(4, 0)), 64'h2b7e1516);
      check("a1_w4", 64'(word(4, 4)), 64'ha0fafe17);
      check("a1_w43", 64'(word(4, 43)), 64'hb6630ca6);
      repeat (3) @(negedge clk);
      check("a1_hold_kv", 64'(if4.key_valid), 64'd1);
      check("a1_hold_w43", 64'(word(4, 43)), 64'hb6630ca6);

      // Restart from DONE with the FIPS-197 C.1 key
      run("c1", 4, KEY_C1, 0, '0, lat);
      check("c1_latency", 64'(lat), 64'd40);
      check("c1_w4", 64'(word(4, 4)), 64'hd6aa74fd);
      check("c1_w43", 64'(word(4, 43)), 64'h4d2b30c5);

      // Start during EXPAND is ignored
      run("ign", 4, KEY_A1, 10, KEY_C1, lat);
      check("ign_latency", 64'(lat), 64'd40);
      check("ign_w4", 64'(word(4, 4)), 64'ha0fafe17);
      check("ign_w43", 64'(word(4, 43)), 64'hb6630ca6);

      // Asynchronous reset mid-expansion
      @(negedge clk);
      drive(4, 1'b1, KEY_C1);
      @(posedge clk);
      @(negedge clk);
      drive(4, 1'b0, KEY_C1);
      repeat (15) @(posedge clk);
      #2;
      check("mid_busy", 64'(if4.busy), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      check("arst_busy", 64'(if4.busy), 64'd0);
      check("arst_kv", 64'(if4.key_valid), 64'd0);
      check("arst_rk_zero", 64'(|if4.round_keys), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_idle", 64'(if4.busy), 64'd0);
      run("a1r", 4, KEY_A1, 0, '0, lat);
      check("a1r_latency", 64'(lat), 64'd40);
      check("a1r_w4", 64'(word(4, 4)), 64'ha0fafe17);
      check("a1r_w43", 64'(word(4, 43)), 64'hb6630ca6);

      // AES-192 FIPS-197 A.2
      run("a2", 6, KEY_A2, 0, '0, lat);
      check("a2_latency", 64'(lat), 64'd46);
      check("a2_w0", 64'(word(6, 0)), 64'h8e73b0f7);
      check("a2_w6", 64'(word(6, 6)), 64'hfe0c91f7);
      check("a2_w51", 64'(word(6, 51)), 64'h01002202);

      // AES-256 FIPS-197 A.3
      run("a3", 8, KEY_A3, 0, '0, lat);
      check("a3_latency", 64'(lat), 64'd52);
      check("a3_w7", 64'(word(8, 7)), 64'h0914dff4);
      check("a3_w8", 64'(word(8, 8)), 64'h9ba35411);
      check("a3_w59", 64'(word(8, 59)), 64'h706c631e);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_schedule_engine.md
# key_schedule_engine

Iterative AES key expansion block that sits directly upstream of the cipher datapath. It turns an Nk-word cipher key into the full Nb·(Nr+1)-word round-key schedule, producing one 32-bit word per clock. It presents the schedule as a flat vector with round key 0 in the most significant 128 bits. A level `key_valid` tells the cipher when the schedule may be consumed.

## Interface
- `Nk`, default 4: key length in 32-bit words; legal values 4, 6, 8.
- `Nr`, default 10: number of rounds; must be 10, 12, 14 for Nk = 4, 6, 8.
- `clk`  input  1: clock; all state on rising edge.
- `reset_n`  input  1: reset, asynchronous, active-low.
- `start`  input  1: request expansion of `key`; one-cycle pulse or level.
- `key`  input  Nk·32: cipher key; word 0 in the MSBs; sampled only on an accepted `start`.
- `round_keys`  output  128·(Nr+1): expanded schedule.
  - w[0] at bits [top −: 32], w[i] at bits [top − 32·i −: 32].
  - Round key r is bits [top − 128·r −: 128].
- `busy`  output  1: expansion in progress.
- `key_valid`  output  1: `round_keys` is complete and stable.

## Operation
- States: IDLE, EXPAND, DONE. Word index `i` is a 6-bit counter; `rcon` is an 8-bit register.
- Accept rule: `start` is accepted in IDLE or DONE. It is ignored in EXPAND, and there is no queueing.
- On an accepted `start`:
  - w[0..Nk−1] ← `key`.
  - i ← Nk; rcon ← 0x01; state → EXPAND.
- EXPAND, one word per cycle:
  - temp = w[i−1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon ← xtime(rcon).
  - Else if Nk = 8 and i mod Nk = 4: temp = SubWord(temp).
  - w[i] ← w[i−Nk] ^ temp; i ← i+1.
- `i mod Nk` uses a separate phase counter that wraps at Nk−1, so no divider is needed.
- xtime: shift left by one; XOR 0x1B if bit 7 was set. rcon runs 01,02,04,…,80,1B,36.
- When w[4(Nr+1)−1] is written, state → DONE.
- DONE: `key_valid` = 1. The schedule is held until the next accepted `start`.
- `key_valid` is 1 only in DONE. `busy` is 1 only in EXPAND.
- During EXPAND, `round_keys` is partially updated, and the consumer must gate on `key_valid`.
- A `start` in DONE drops `key_valid` on the next edge and restarts expansion with the new key.

## Timing
- Reset (asynchronous): state IDLE, i = 0, rcon = 0x01, `round_keys` = 0, `busy` = 0, `key_valid` = 0.
- Reset mid-EXPAND aborts immediately to the reset values; a fresh `start` is then required.
- `start` sampled at edge t: `busy` = 1 after edge t, with words w[Nk]… written at edges t+1 onward.
- Latency from the accepting edge to `key_valid` = 1 is 4(Nr+1)−Nk cycles:
  - 40 for Nk = 4.
  - 46 for Nk = 6.
  - 52 for Nk = 8.
- `busy` falls and `key_valid` rises on the same edge.
- The last generated word w[4(Nr+1)−1] is visible in `round_keys` in the same cycle as `key_valid` = 1.
- Outputs are registered only; there is no combinational path from `start` to any output.

## Structure
- Shared package `aes_pkg`:
  - Nb = 4, WORD_SIZE = 32, BLOCK_SIZE = 128.
  - The AES S-box constant table.
  - The `xtime` function.
  - The state enum (IDLE/EXPAND/DONE).
- Sub-module `sub_word`: 32-bit in and out, four byte-wise S-box lookups, purely combinational, and reusable by the cipher's byte-substitution stage.
- Top module: FSM, counters, rcon register, the w[] register array, and the flat output mapping.

## Test plan
- AES-128 (FIPS-197 A.1): key 2b7e151628aed2a6abf7158809cf4f3c, start → `key_valid` exactly 40 cycles later, w[4] = a0fafe17, w[43] = b6630ca6.
- AES-192 (A.2): key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → `key_valid` after 46 cycles, w[6] = fe0c91f7, w[51] = 01002202.
- AES-256 (A.3): key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → `key_valid` after 52 cycles, w[8] = 9ba35411, w[59] = 706c631e.
- `start` re-asserted with a different key at cycle 10 of EXPAND → ignored; the schedule matches the first key; latency is unchanged.
- `reset_n` asserted mid-EXPAND → all outputs 0 asynchronously; a new start with the A.1 key → correct schedule after 40 cycles.
- `start` in DONE with a new key → `key_valid` drops next edge, `busy` = 1, and the new schedule is correct after the full latency.
